usb_device_state: RTL and testbench

//  Device-level USB state controller. Consumes the bus-reset pulse from the SE0 reset

---
 rtl/usb_device_state_pkg.sv | 32 +++
 rtl/usb_device_state_if.sv | 39 +++
 rtl/usb_device_state_ms_timer.sv | 30 +++
 rtl/usb_device_state.sv | 180 ++++++++++++++++++
 tb/tb_usb_device_state.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/usb_device_state_pkg.sv
// Shared types and timing helpers for the USB device-state controller.
// The default clock rate follows the selected bus speed; the bench overrides it.
package usb_device_state_pkg;

  localparam bit USB_FULL_SPEED = 1'b1;
  localparam int CLK_KHZ_DFLT   = USB_FULL_SPEED ? 48000 : 6000;

  typedef enum logic [1:0] {
    POWERED    = 2'd0,
    DEFAULT    = 2'd1,
    ADDRESS    = 2'd2,
    CONFIGURED = 2'd3
  } dev_state_t;

  typedef enum logic [1:0] {
    AWAKE      = 2'd0,
    SUSP_WAIT  = 2'd1,
    SUSP_READY = 2'd2,
    DRIVE_K    = 2'd3
  } susp_state_t;

  function automatic int ms_cycles(input int ms, input int khz);
    return ms * khz;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/usb_device_state_if.sv
// Signal bundle between PHY/reset detector/control endpoint and the device-state block.
// master drives the line and strobe inputs; slave is the state controller.
interface usb_device_state_if;
  import usb_device_state_pkg::*;

  logic        bus_reset_i;
  logic        line_j_i;
  logic        line_k_i;
  logic        set_addr_i;
  logic [6:0]  addr_i;
  logic        set_cfg_i;
  logic [7:0]  cfg_i;
  logic        rwake_en_i;
  logic        rwake_req_i;

  dev_state_t  dev_state_o;
  logic [6:0]  dev_addr_o;
  logic [7:0]  cfg_o;
  logic        suspend_o;
  logic        resume_o;
  logic        drive_k_o;

  modport master (
    output bus_reset_i, line_j_i, line_k_i,
    output set_addr_i, addr_i, set_cfg_i, cfg_i,
    output rwake_en_i, rwake_req_i,
    input  dev_state_o, dev_addr_o, cfg_o,
    input  suspend_o, resume_o, drive_k_o
  );

  modport slave (
    input  bus_reset_i, line_j_i, line_k_i,
    input  set_addr_i, addr_i, set_cfg_i, cfg_i,
    input  rwake_en_i, rwake_req_i,
    output dev_state_o, dev_addr_o, cfg_o,
    output suspend_o, resume_o, drive_k_o
  );

endinterface

// File: rtl/usb_device_state_ms_timer.sv
// Saturating cycle counter with synchronous clear; done is high while the count equals TC.
// Clear takes priority over enable.
module usb_ms_timer #(
  parameter int W  = 8,
  parameter int TC = 1
) (
  input  logic clk,
  input  logic reset_ni,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != TC_V)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done = (cnt_q == TC_V);

endmodule

// File: rtl/usb_device_state.sv
// Chapter-9 device state plus suspend / host-resume / remote-wakeup sequencing.
// All outputs are registered; bus reset overrides everything in the cycle it is seen.
module usb_device_state
  import usb_device_state_pkg::*;
#(
  parameter int CLK_KHZ     = CLK_KHZ_DFLT,
  parameter int T_SUSP_MS   = 3,
  parameter int T_RWIDLE_MS = 2,
  parameter int T_RWDRV_MS  = 2
) (
  input  logic              clk,
  input  logic              reset_ni,
  usb_device_state_if.slave bus
);

  localparam int SUSP_CYC   = ms_cycles(T_SUSP_MS, CLK_KHZ);
  localparam int RWIDLE_CYC = ms_cycles(T_RWIDLE_MS, CLK_KHZ);
  localparam int RWDRV_CYC  = ms_cycles(T_RWDRV_MS, CLK_KHZ);
  localparam int MAX_CYC    = max3(SUSP_CYC, RWIDLE_CYC, RWDRV_CYC);
  localparam int TW         = $clog2(MAX_CYC) + 1;

  dev_state_t  dev_state_q, dev_state_d;
  logic [6:0]  addr_q, addr_d;
  logic [7:0]  cfg_q, cfg_d;
  susp_state_t susp_q, susp_d;
  logic        resume_q, resume_d;

  logic        suspended;
  logic        rwake_go;
  logic        idle_clr, dwell_clr, drv_clr;
  logic        idle_done, dwell_done, drv_done;

  assign suspended = (susp_q != AWAKE);
  assign rwake_go  = bus.rwake_en_i && bus.rwake_req_i;

  // Idle timer: consecutive J cycles while awake.
  assign idle_clr  = bus.bus_reset_i || !bus.line_j_i || suspended;
  // Dwell and drive timers leave their state on the edge after done, so their
  // terminal counts sit one below the cycle count to land exactly N cycles after entry.
  assign dwell_clr = bus.bus_reset_i || (susp_q != SUSP_WAIT);
  assign drv_clr   = bus.bus_reset_i || (susp_q != DRIVE_K);

  usb_ms_timer #(.W(TW), .TC(SUSP_CYC)) u_idle_tmr (
    .clk      (clk),
    .reset_ni (reset_ni),
    .clr      (idle_clr),
    .en       (bus.line_j_i),
    .done     (idle_done)
  );

  usb_ms_timer #(.W(TW), .TC(RWIDLE_CYC - 1)) u_dwell_tmr (
    .clk      (clk),
    .reset_ni (reset_ni),
    .clr      (dwell_clr),
    .en       (susp_q == SUSP_WAIT),
    .done     (dwell_done)
  );

  usb_ms_timer #(.W(TW), .TC(RWDRV_CYC - 1)) u_drv_tmr (
    .clk      (clk),
    .reset_ni (reset_ni),
    .clr      (drv_clr),
    .en       (susp_q == DRIVE_K),
    .done     (drv_done)
  );

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      dev_state_q <= POWERED;
      addr_q      <= '0;
      cfg_q       <= '0;
      susp_q      <= AWAKE;
      resume_q    <= 1'b0;
    end else begin
      dev_state_q <= dev_state_d;
      addr_q      <= addr_d;
      cfg_q       <= cfg_d;
      susp_q      <= susp_d;
      resume_q    <= resume_d;
    end
  end

  // Device state: set_addr has priority over set_cfg in the same cycle.
  always_comb begin
    dev_state_d = dev_state_q;
    addr_d      = addr_q;
    cfg_d       = cfg_q;
    if (bus.bus_reset_i) begin
      dev_state_d = DEFAULT;
      addr_d      = '0;
      cfg_d       = '0;
    end else if (!suspended) begin
      if (bus.set_addr_i) begin
        unique case (dev_state_q)
          DEFAULT: begin
            if (bus.addr_i != 7'd0) begin
              dev_state_d = ADDRESS;
              addr_d      = bus.addr_i;
            end
          end
          ADDRESS: begin
            if (bus.addr_i != 7'd0) begin
              addr_d = bus.addr_i;
            end else begin
              dev_state_d = DEFAULT;
              addr_d      = '0;
            end
          end
          default: ;
        endcase
      end else if (bus.set_cfg_i) begin
        unique case (dev_state_q)
          ADDRESS: begin
            if (bus.cfg_i != 8'd0) begin
              dev_state_d = CONFIGURED;
              cfg_d       = bus.cfg_i;
            end
          end
          CONFIGURED: begin
            if (bus.cfg_i == 8'd0) begin
              dev_state_d = ADDRESS;
              cfg_d       = '0;
            end else begin
              cfg_d = bus.cfg_i;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Suspend / wakeup: host K resumes from any suspended state except while we drive K.
  always_comb begin
    susp_d   = susp_q;
    resume_d = 1'b0;
    if (bus.bus_reset_i) begin
      susp_d   = AWAKE;
      resume_d = suspended;
    end else begin
      unique case (susp_q)
        AWAKE: begin
          if (idle_done && bus.line_j_i) begin
            susp_d = SUSP_WAIT;
          end
        end
        SUSP_WAIT: begin
          if (bus.line_k_i) begin
            susp_d   = AWAKE;
            resume_d = 1'b1;
          end else if (dwell_done) begin
            susp_d = rwake_go ? DRIVE_K : SUSP_READY;
          end
        end
        SUSP_READY: begin
          if (bus.line_k_i) begin
            susp_d   = AWAKE;
            resume_d = 1'b1;
          end else if (rwake_go) begin
            susp_d = DRIVE_K;
          end
        end
        DRIVE_K: begin
          if (drv_done) begin
            susp_d = SUSP_WAIT;
          end
        end
        default: susp_d = AWAKE;
      endcase
    end
  end

  assign bus.dev_state_o = dev_state_q;
  assign bus.dev_addr_o  = addr_q;
  assign bus.cfg_o       = cfg_q;
  assign bus.suspend_o   = suspended;
  assign bus.resume_o    = resume_q;
  assign bus.drive_k_o   = (susp_q == DRIVE_K);

endmodule

// File: tb/tb_usb_device_state.sv
// Directed bench for usb_device_state at CLK_KHZ=4 (3 ms = 12 cycles, 2 ms = 8 cycles).
module tb_usb_device_state;
  import usb_device_state_pkg::*;

  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  usb_device_state_if ifc ();

  usb_device_state #(
    .CLK_KHZ     (4),
    .T_SUSP_MS   (3),
    .T_RWIDLE_MS (2),
    .T_RWDRV_MS  (2)
  ) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (ifc)
  );

  typedef struct {
    logic       bus_reset;
    logic       set_addr;
    logic [6:0] addr;
    logic       set_cfg;
    logic [7:0] cfg;
    dev_state_t e_state;
    logic [6:0] e_addr;
    logic [7:0] e_cfg;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkv(input logic br, input logic sa, input logic [6:0] a,
                               input logic sc, input logic [7:0] c, input dev_state_t es,
                               input logic [6:0] ea, input logic [7:0] ec);
    vec_t v;
    v.bus_reset = br; v.set_addr = sa; v.addr = a; v.set_cfg = sc; v.cfg = c;
    v.e_state = es; v.e_addr = ea; v.e_cfg = ec;
    return v;
  endfunction

  task automatic cmp(input string tag, input string what, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, what, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input dev_state_t st, input logic [6:0] a,
                            input logic [7:0] c, input logic s, input logic r, input logic d);
    cmp(tag, "state",   {6'd0, ifc.dev_state_o}, {6'd0, st});
    cmp(tag, "addr",    {1'b0, ifc.dev_addr_o},  {1'b0, a});
    cmp(tag, "cfg",     ifc.cfg_o,               c);
    cmp(tag, "suspend", {7'd0, ifc.suspend_o},   {7'd0, s});
    cmp(tag, "resume",  {7'd0, ifc.resume_o},    {7'd0, r});
    cmp(tag, "drive_k", {7'd0, ifc.drive_k_o},   {7'd0, d});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic j, input logic k);
    ifc.line_j_i = j;
    ifc.line_k_i = k;
  endtask

  initial begin
    ifc.bus_reset_i = 1'b0; ifc.line_j_i = 1'b1; ifc.line_k_i = 1'b0;
    ifc.set_addr_i = 1'b0;  ifc.addr_i = '0;     ifc.set_cfg_i = 1'b0;
    ifc.cfg_i = '0;         ifc.rwake_en_i = 1'b0; ifc.rwake_req_i = 1'b0;

    vecs[0]  = mkv(0, 1, 7'h05, 0, 8'h00, POWERED,    7'h00, 8'h00);
    vecs[1]  = mkv(0, 0, 7'h00, 1, 8'h03, POWERED,    7'h00, 8'h00);
    vecs[2]  = mkv(1, 0, 7'h00, 0, 8'h00, DEFAULT,    7'h00, 8'h00);
    vecs[3]  = mkv(0, 0, 7'h00, 1, 8'h03, DEFAULT,    7'h00, 8'h00);
    vecs[4]  = mkv(0, 1, 7'h00, 0, 8'h00, DEFAULT,    7'h00, 8'h00);
    vecs[5]  = mkv(0, 1, 7'h05, 0, 8'h00, ADDRESS,    7'h05, 8'h00);
    vecs[6]  = mkv(0, 1, 7'h12, 0, 8'h00, ADDRESS,    7'h12, 8'h00);
    vecs[7]  = mkv(0, 1, 7'h00, 0, 8'h00, DEFAULT,    7'h00, 8'h00);
    vecs[8]  = mkv(0, 1, 7'h05, 0, 8'h00, ADDRESS,    7'h05, 8'h00);
    vecs[9]  = mkv(0, 0, 7'h00, 1, 8'h00, ADDRESS,    7'h05, 8'h00);
    vecs[10] = mkv(0, 0, 7'h00, 1, 8'h01, CONFIGURED, 7'h05, 8'h01);
    vecs[11] = mkv(0, 1, 7'h09, 0, 8'h00, CONFIGURED, 7'h05, 8'h01);
    vecs[12] = mkv(0, 0, 7'h00, 1, 8'h02, CONFIGURED, 7'h05, 8'h02);
    vecs[13] = mkv(0, 0, 7'h00, 1, 8'h00, ADDRESS,    7'h05, 8'h00);
    vecs[14] = mkv(0, 1, 7'h07, 1, 8'h03, ADDRESS,    7'h07, 8'h00);
    vecs[15] = mkv(0, 0, 7'h00, 1, 8'h01, CONFIGURED, 7'h07, 8'h01);

    // Reset state, then idle J from release: suspend on the 13th edge.
    #1;
    check_outs("reset", POWERED, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #21;
    reset_ni = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step();
      cmp("idle_powered", $sformatf("susp@%0d", i), {7'd0, ifc.suspend_o}, {7'd0, (i >= 13)});
    end
    set_line(1'b0, 1'b1);
    step();
    check_outs("resume_powered", POWERED, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    set_line(1'b0, 1'b0);
    step();
    check_outs("resume_drop", POWERED, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Strobe table, line neither J nor K.
    for (int i = 0; i < 16; i++) begin
      ifc.bus_reset_i = vecs[i].bus_reset;
      ifc.set_addr_i  = vecs[i].set_addr;
      ifc.addr_i      = vecs[i].addr;
      ifc.set_cfg_i   = vecs[i].set_cfg;
      ifc.cfg_i       = vecs[i].cfg;
      step();
      check_outs($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_addr, vecs[i].e_cfg,
                 1'b0, 1'b0, 1'b0);
    end
    ifc.bus_reset_i = 1'b0; ifc.set_addr_i = 1'b0; ifc.set_cfg_i = 1'b0;

    // 11 J, 1 K, 11 J: no suspend; one more J then suspend on the next edge.
    set_line(1'b1, 1'b0);
    repeat (11) step();
    set_line(1'b0, 1'b1);
    step();
    set_line(1'b1, 1'b0);
    repeat (11) step();
    cmp("k_clears_idle", "susp", {7'd0, ifc.suspend_o}, 8'd0);
    step();
    cmp("idle_12", "susp", {7'd0, ifc.suspend_o}, 8'd0);
    step();
    check_outs("susp_cfg", CONFIGURED, 7'h07, 8'h01, 1'b1, 1'b0, 1'b0);
    ifc.set_cfg_i = 1'b1; ifc.cfg_i = 8'h00;
    step();
    ifc.set_cfg_i = 1'b0;
    check_outs("strobe_in_susp", CONFIGURED, 7'h07, 8'h01, 1'b1, 1'b0, 1'b0);
    set_line(1'b0, 1'b1);
    step();
    check_outs("host_resume", CONFIGURED, 7'h07, 8'h01, 1'b0, 1'b1, 1'b0);
    set_line(1'b1, 1'b0);
    step();
    cmp("host_resume_pulse", "resume", {7'd0, ifc.resume_o}, 8'd0);

    // Remote wakeup: re-suspend, request at cycle 3, K driven over suspend+8..+15.
    repeat (12) step();
    cmp("rw_susp", "susp", {7'd0, ifc.suspend_o}, 8'd1);
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) begin
        ifc.rwake_en_i = 1'b1; ifc.rwake_req_i = 1'b1;
      end
      if (k >= 10 && k <= 12) set_line(1'b0, 1'b1);
      else set_line(1'b1, 1'b0);
      step();
      cmp("rwake", $sformatf("drive_k@%0d", k), {7'd0, ifc.drive_k_o},
          {7'd0, (k >= 8 && k <= 15)});
      cmp("rwake", $sformatf("susp@%0d", k), {7'd0, ifc.suspend_o}, 8'd1);
      if (k == 8) ifc.rwake_req_i = 1'b0;
    end
    set_line(1'b0, 1'b1);
    step();
    check_outs("rw_host_resume", CONFIGURED, 7'h07, 8'h01, 1'b0, 1'b1, 1'b0);

    // rwake_en low: request held but never honoured.
    set_line(1'b1, 1'b0);
    ifc.rwake_en_i = 1'b0; ifc.rwake_req_i = 1'b1;
    repeat (13) step();
    cmp("noen_susp", "susp", {7'd0, ifc.suspend_o}, 8'd1);
    for (int k = 1; k <= 20; k++) begin
      step();
      cmp("noen", $sformatf("drive_k@%0d", k), {7'd0, ifc.drive_k_o}, 8'd0);
    end

    // Enable now: READY goes straight to DRIVE_K; bus reset mid-drive wins over set_addr.
    ifc.rwake_en_i = 1'b1;
    step();
    cmp("late_en", "drive_k", {7'd0, ifc.drive_k_o}, 8'd1);
    ifc.bus_reset_i = 1'b1; ifc.set_addr_i = 1'b1; ifc.addr_i = 7'h33;
    set_line(1'b0, 1'b0);
    step();
    check_outs("reset_in_drive", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    ifc.bus_reset_i = 1'b0; ifc.set_addr_i = 1'b0;
    ifc.rwake_en_i = 1'b0;  ifc.rwake_req_i = 1'b0;
    step();
    check_outs("after_reset", DEFAULT, 7'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
